// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE single layout, constants, operand classifier
// and the divider state encoding.
package fpu_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} fdiv_state_t;

  typedef enum logic [1:0] {FP_ZERO, FP_INF, FP_NAN, FP_NORMAL} fp_class_t;

  // Denormals classify as zero: the FPU flushes them on input.
  function automatic fp_class_t fp_classify(input fp32_t f);
    if (f.exp == 8'd0)                         return FP_ZERO;
    else if (f.exp == EXP_MAX && f.mant != '0) return FP_NAN;
    else if (f.exp == EXP_MAX)                 return FP_INF;
    else                                       return FP_NORMAL;
  endfunction

endpackage

// File: rtl/fdiv_round_pack.sv
// Normalise a 26-bit quotient, round to nearest even and pack an IEEE single,
// saturating to infinity on overflow and flushing to zero on underflow.
module fdiv_round_pack
  import fpu_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,    // biased exponent assuming q_i[25] == 0
  input  logic [25:0]       q_i,
  input  logic              sticky_i,
  output logic [31:0]       y_o,
  output logic              ovf_o
);

  logic [22:0]       mant;
  logic [22:0]       mant_r;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic              carry;
  logic signed [9:0] e;

  always_comb begin
    mant   = q_i[25] ? q_i[24:2] : q_i[23:1];
    guard  = q_i[25] ? q_i[1] : q_i[0];
    sticky = sticky_i | (q_i[25] & q_i[0]);
    e      = exp_i + 10'(q_i[25]);

    round_up = guard & (sticky | mant[0]);
    // The hidden bit is always set, so a carry out needs all stored bits set.
    carry    = round_up & (&mant);
    mant_r   = mant + 23'(round_up);
    if (carry) e = e + 10'sd1;

    y_o   = '0;
    ovf_o = 1'b0;
    if (e >= 10'sd255) begin
      y_o   = {sign_i, EXP_MAX, 23'd0};
      ovf_o = 1'b1;
    end else if (e <= 10'sd0) begin
      y_o = {sign_i, 31'd0};
    end else begin
      y_o = {sign_i, e[7:0], mant_r};
    end
  end

endmodule

// File: rtl/fdiv.sv
// Multi-cycle IEEE single divider y = x1 / x2 using a restoring mantissa divider.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high only in IDLE.
module fdiv
  import fpu_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        dz,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int NSTEPS = 26 / RADIX_BITS;

  fdiv_state_t       state_q, state_d;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [25:0]       rem_q, rem_d;
  logic [25:0]       quo_q, quo_d;
  logic [23:0]       m2_q;
  logic [4:0]        cnt_q;
  logic [31:0]       y_q;
  logic              ovf_q, dz_q;

  fp32_t             a, b;
  fp_class_t         ca, cb;
  logic              s_in;
  logic              special;
  logic [31:0]       spec_y;
  logic              spec_dz;
  logic signed [9:0] exp_in;
  logic              last_step;
  logic [31:0]       rp_y;
  logic              rp_ovf;

  assign a         = x1;
  assign b         = x2;
  assign ca        = fp_classify(a);
  assign cb        = fp_classify(b);
  assign s_in      = a.sign ^ b.sign;
  assign exp_in    = 10'({2'b00, a.exp}) - 10'({2'b00, b.exp}) + 10'(EXP_BIAS - 1);
  assign last_step = (cnt_q == 5'(NSTEPS - 1));

  always_comb begin
    special = 1'b1;
    spec_y  = QNAN;
    spec_dz = 1'b0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      spec_y = QNAN;
    end else if ((ca == FP_ZERO && cb == FP_ZERO) || (ca == FP_INF && cb == FP_INF)) begin
      spec_y = QNAN;
    end else if (cb == FP_ZERO && ca == FP_NORMAL) begin
      spec_y  = {s_in, EXP_MAX, 23'd0};
      spec_dz = 1'b1;
    end else if (ca == FP_INF) begin
      spec_y = {s_in, EXP_MAX, 23'd0};
    end else if (ca == FP_ZERO || cb == FP_INF) begin
      spec_y = {s_in, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step per quotient bit, MSB first; remainder is kept pre-shifted.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (rem_d >= {2'b00, m2_q}) begin
        rem_d = (rem_d - {2'b00, m2_q}) << 1;
        quo_d = {quo_d[24:0], 1'b1};
      end else begin
        rem_d = rem_d << 1;
        quo_d = {quo_d[24:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = special ? S_DONE : S_DIV;
      S_DIV:  if (last_step) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      m2_q   <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sign_q <= s_in;
          exp_q  <= exp_in;
          rem_q  <= {2'b00, 1'b1, a.mant};
          m2_q   <= {1'b1, b.mant};
          quo_q  <= '0;
          cnt_q  <= '0;
          if (special) begin
            y_q   <= spec_y;
            ovf_q <= 1'b0;
            dz_q  <= spec_dz;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
        end
        S_NORM: begin
          y_q   <= rp_y;
          ovf_q <= rp_ovf;
          dz_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fdiv_round_pack u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .q_i      (quo_q),
    .sticky_i (rem_q != 26'd0),
    .y_o      (rp_y),
    .ovf_o    (rp_ovf)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_fdiv.sv
// Scoreboard bench for fdiv: radix-1 and radix-2 instances share operands and
// are checked against an exact-integer reference model.
module tb_fdiv;

  localparam int W = 74;  // {y[31:0], ovf, dz, latency[7:0], accept_cycle[31:0]}

  logic        clk, rst;
  logic [31:0] x1, x2;
  logic        in_valid;
  logic        out_ready, fixed_rdy, rnd_rdy, rnd_en;
  logic        in_ready1, out_valid1, ovf1, dz1;
  logic        in_ready2, out_valid2, ovf2, dz2;
  logic [31:0] y1, y2;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp2_q[$];
  logic         seen1, seen2;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  fdiv #(.RADIX_BITS(1)) u_r1 (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(in_ready1),
    .y(y1), .ovf(ovf1), .dz(dz1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  fdiv #(.RADIX_BITS(2)) u_r2 (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(in_ready2),
    .y(y2), .ovf(ovf2), .dz(dz2), .out_valid(out_valid2), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);
  assign out_ready = rnd_en ? rnd_rdy : fixed_rdy;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endfunction

  // Reference: returns {special, y, ovf, dz}. Normal operands are divided exactly
  // with wide integers, then rounded to nearest even on the discarded bits.
  function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e, sh;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    logic [79:0] num, den, quo, rmd, low, half;
    logic [24:0] mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {1'b1, 32'h7FC00000, 2'b00};
    if ((a_zero && b_zero) || (a_inf && b_inf)) return {1'b1, 32'h7FC00000, 2'b00};
    if (b_zero && !a_inf) return {1'b1, s, 8'hFF, 23'd0, 2'b01};
    if (a_inf) return {1'b1, s, 8'hFF, 23'd0, 2'b00};
    if (a_zero || b_inf) return {1'b1, s, 31'd0, 2'b00};
    num = {56'd0, 1'b1, a[22:0]} << 48;
    den = {56'd0, 1'b1, b[22:0]};
    quo = num / den;
    rmd = num % den;
    if (quo[48]) begin sh = 25; e = ea - eb + 127; end
    else         begin sh = 24; e = ea - eb + 126; end
    mant = 25'(quo >> sh);
    low  = quo & ((80'd1 << sh) - 80'd1);
    half = 80'd1 << (sh - 1);
    up   = (low > half) || ((low == half) && ((rmd != 0) || mant[0]));
    mant = mant + 25'(up);
    if (mant[24]) begin mant = 25'h0800000; e = e + 1; end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'd0, 2'b10};
    if (e <= 0)   return {1'b0, s, 31'd0, 2'b00};
    return {1'b0, s, e[7:0], mant[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] gen_fp();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    k = $urandom_range(0, 15);
    m = 23'($urandom);
    if (k == 0)      e = 8'd0;
    else if (k == 1) begin e = 8'hFF; m = '0; end
    else if (k == 2) begin e = 8'hFF; m = m | 23'd1; end
    else if (k <= 6) e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(225, 254));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // driver tasks: called and return at #1 after a rising edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    logic [34:0] r;
    int          t;
    t = 0;
    while (!(in_ready1 && in_ready2) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    chk("issue in_ready", {62'd0, in_ready2, in_ready1}, 64'd3);
    r = ref_div(a, b);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    exp1_q.push_back({r[33:0], r[34] ? 8'd1 : 8'd28, 32'(cyc + 1)});
    exp2_q.push_back({r[33:0], r[34] ? 8'd1 : 8'd15, 32'(cyc + 1)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp1_q.size() != 0 || exp2_q.size() != 0) && t < 600) begin
      @(posedge clk); #1; t++;
    end
    chk("drain outstanding results", 64'(exp1_q.size() + exp2_q.size()), 64'd0);
    exp1_q.delete();
    exp2_q.delete();
    seen1 = 1'b0;
    seen2 = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (exp1_q.size() == 0) chk("r1 idle out_valid", 64'(out_valid1), 64'd0);
      else if (out_valid1) begin
        if (!seen1) begin
          seen1 = 1'b1;
          chk("r1 latency", 64'(cyc - int'(exp1_q[0][31:0]) + 1), 64'(exp1_q[0][39:32]));
        end
        if (out_ready) begin
          chk("r1 y", 64'(y1), 64'(exp1_q[0][73:42]));
          chk("r1 ovf", 64'(ovf1), 64'(exp1_q[0][41]));
          chk("r1 dz", 64'(dz1), 64'(exp1_q[0][40]));
          void'(exp1_q.pop_front());
          seen1 = 1'b0;
        end
      end
      if (exp2_q.size() == 0) chk("r2 idle out_valid", 64'(out_valid2), 64'd0);
      else if (out_valid2) begin
        if (!seen2) begin
          seen2 = 1'b1;
          chk("r2 latency", 64'(cyc - int'(exp2_q[0][31:0]) + 1), 64'(exp2_q[0][39:32]));
        end
        if (out_ready) begin
          chk("r2 y", 64'(y2), 64'(exp2_q[0][73:42]));
          chk("r2 ovf", 64'(ovf2), 64'(exp2_q[0][41]));
          chk("r2 dz", 64'(dz2), 64'(exp2_q[0][40]));
          void'(exp2_q.pop_front());
          seen2 = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] hold_y;
    int          t;
    rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0;
    fixed_rdy = 1'b1; rnd_en = 1'b0; seen1 = 1'b0; seen2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {62'd0, in_ready2, in_ready1}, 64'd3);
    chk("reset out_valid", {62'd0, out_valid2, out_valid1}, 64'd0);
    chk("reset y", {y2, y1}, 64'd0);
    chk("reset ovf/dz", {60'd0, ovf2, dz2, ovf1, dz1}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed operands from the plan
    issue(32'h40C00000, 32'h40000000); drain();
    issue(32'h3F800000, 32'h40400000); drain();
    issue(32'hBF800000, 32'h00000000); drain();
    issue(32'h00000000, 32'h00000000); drain();
    issue(32'h7F000000, 32'h00800000); drain();
    issue(32'h00800000, 32'h7F000000); drain();
    issue(32'h7F800000, 32'h00000000); drain();
    issue(32'h3F800000, 32'h7F800000); drain();
    issue(32'h7FC00001, 32'h3F800000); drain();

    // hold the result under backpressure while new operands are offered
    fixed_rdy = 1'b0;
    hold_y = ref_div(32'h40C00000, 32'h40000000)[33:2];
    issue(32'h40C00000, 32'h40000000);
    t = 0;
    while (!(out_valid1 && out_valid2) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("hold reached DONE", {62'd0, out_valid2, out_valid1}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      x1 = gen_fp(); x2 = gen_fp(); in_valid = 1'b1;
      @(negedge clk);
      chk("hold y", {y2, y1}, {hold_y, hold_y});
      chk("hold in_ready", {62'd0, in_ready2, in_ready1}, 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    fixed_rdy = 1'b1;
    drain();
    issue(32'h3F800000, 32'h40400000); drain();

    // asynchronous reset in the middle of DIV
    issue(32'h40C00000, 32'h40000000);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid-DIV reset out_valid", {62'd0, out_valid2, out_valid1}, 64'd0);
    chk("mid-DIV reset in_ready", {62'd0, in_ready2, in_ready1}, 64'd3);
    exp1_q.delete(); exp2_q.delete(); seen1 = 1'b0; seen2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(32'h40C00000, 32'h40000000); drain();

    // randomized operands with random backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 80; i++) issue(gen_fp(), gen_fp());
    drain();
    rnd_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
